// File: rtl/lsf_hit_feeder_pkg.sv
// Shared types and widths for the LSF hit feeder (event builder in front of the Legendre engine).
// HPS_LSF_LEN / SLCPROC_HPS_SF_LEN mirror the values in l0mdt_buses_constants.svh.
package lsf_feeder_pkg;

  localparam int HPS_LSF_LEN        = 40;
  localparam int SLCPROC_HPS_SF_LEN = 39;
  localparam int MAX_HITS_DEFAULT   = 32;

  // Width needed to hold 0..max_hits without wrapping.
  function automatic int count_width(input int max_hits);
    return $clog2(max_hits + 1);
  endfunction

  localparam int COUNT_W = count_width(MAX_HITS_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CLOSE
  } feeder_state_t;

  typedef struct packed {
    logic [COUNT_W-1:0]            count;
    logic [SLCPROC_HPS_SF_LEN-1:0] roi;
  } evt_entry_t;

endpackage

// File: rtl/lsf_hit_feeder_if.sv
// Bundle of the upstream event-building inputs and the engine-facing FWFT FIFO ports.
// slave = feeder view, master = upstream/engine view.
interface lsf_hit_feeder_if #(
  parameter int HIT_W = lsf_feeder_pkg::HPS_LSF_LEN,
  parameter int ROI_W = lsf_feeder_pkg::SLCPROC_HPS_SF_LEN
);

  logic [ROI_W-1:0] roi_in;
  logic             roi_in_vld;
  logic [HIT_W-1:0] hit_in;
  logic             hit_in_vld;
  logic             hit_in_last;
  logic             eoe_in;
  logic             in_ready;

  logic [HIT_W-1:0] mdt_hit_top;
  logic             mdt_hit_top_empty;
  logic             mdt_hit_top_re;

  logic [ROI_W-1:0] hit_extraction_roi_top;
  logic             hit_extraction_roi_empty;
  logic             hit_extraction_roi_re;
  logic [9:0]       histogram_accumulation_count;

  logic [15:0]      dropped_hits;
  logic [15:0]      events_out;

  modport slave (
    input  roi_in, roi_in_vld, hit_in, hit_in_vld, hit_in_last, eoe_in,
    input  mdt_hit_top_re, hit_extraction_roi_re,
    output in_ready, mdt_hit_top, mdt_hit_top_empty,
    output hit_extraction_roi_top, hit_extraction_roi_empty,
    output histogram_accumulation_count, dropped_hits, events_out
  );

  modport master (
    output roi_in, roi_in_vld, hit_in, hit_in_vld, hit_in_last, eoe_in,
    output mdt_hit_top_re, hit_extraction_roi_re,
    input  in_ready, mdt_hit_top, mdt_hit_top_empty,
    input  hit_extraction_roi_top, hit_extraction_roi_empty,
    input  histogram_accumulation_count, dropped_hits, events_out
  );

endinterface

// File: rtl/lsf_hit_feeder_fifo.sv
// Generic synchronous first-word-fall-through FIFO (lsf_fwft_fifo), DEPTH a power of 2 and >= 2.
// Head data is forced to zero while empty so stale RAM contents never leak out.
module lsf_fwft_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;

  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(do_rd);
    end
  end

  // Storage is deliberately unreset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Callers guarantee space before writing, so a write into a full FIFO is a design bug.
  assert property (@(posedge clk) disable iff (rst) wr_en |-> (level != LW'(DEPTH)));

endmodule

// File: rtl/lsf_hit_feeder.sv
// Event-building input buffer for the LSF Legendre engine: one ROI plus capped hit stream per event.
// Optional statistics counters are built when LSF_FEEDER_STATS_EN is defined.
module lsf_hit_feeder
  import lsf_feeder_pkg::*;
#(
  parameter int HIT_W     = HPS_LSF_LEN,
  parameter int ROI_W     = SLCPROC_HPS_SF_LEN,
  parameter int HIT_DEPTH = 64,
  parameter int EVT_DEPTH = 4,
  parameter int MAX_HITS  = MAX_HITS_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  lsf_hit_feeder_if.slave bus
);

  localparam int CNT_W = count_width(MAX_HITS);
  localparam int EW    = CNT_W + ROI_W;
  localparam int HLW   = $clog2(HIT_DEPTH) + 1;
  localparam int ELW   = $clog2(EVT_DEPTH) + 1;

  feeder_state_t    state;
  feeder_state_t    state_nxt;
  logic [ROI_W-1:0] roi_q;
  logic [CNT_W-1:0] cnt;
  logic             roi_take;
  logic             hit_push;
  logic             evt_push;
  logic             room_ok;
  logic             ready;
  logic [HLW-1:0]   hit_level;
  logic [HLW-1:0]   hit_free;
  logic [ELW-1:0]   evt_level;
  logic [HIT_W-1:0] hit_dout;
  logic             hit_empty;
  logic [EW-1:0]    evt_dout;
  logic             evt_empty;

  // A new event is admitted only when a worst-case event is guaranteed to fit,
  // which is what makes the FIFO full-write impossible.
  assign hit_free = HLW'(HIT_DEPTH) - hit_level;
  assign room_ok  = (evt_level != ELW'(EVT_DEPTH)) && (hit_free >= HLW'(MAX_HITS));
  assign ready    = !rst && (state == IDLE) && room_ok;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    roi_take  = 1'b0;
    hit_push  = 1'b0;
    evt_push  = 1'b0;
    case (state)
      IDLE: begin
        if (ready && bus.roi_in_vld) begin
          roi_take  = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.hit_in_vld && (cnt < CNT_W'(MAX_HITS))) hit_push = 1'b1;
        if ((bus.hit_in_vld && bus.hit_in_last) || bus.eoe_in) state_nxt = CLOSE;
      end
      CLOSE: begin
        evt_push  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      roi_q <= '0;
      cnt   <= '0;
    end else if (roi_take) begin
      roi_q <= bus.roi_in;
      cnt   <= '0;
    end else if (hit_push) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  lsf_fwft_fifo #(.W(HIT_W), .DEPTH(HIT_DEPTH)) u_hit_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hit_push),
    .wr_data (bus.hit_in),
    .rd_en   (bus.mdt_hit_top_re),
    .rd_data (hit_dout),
    .empty   (hit_empty),
    .level   (hit_level)
  );

  // Event entries are written in CLOSE, strictly after the event's last hit write.
  lsf_fwft_fifo #(.W(EW), .DEPTH(EVT_DEPTH)) u_evt_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (evt_push),
    .wr_data ({cnt, roi_q}),
    .rd_en   (bus.hit_extraction_roi_re),
    .rd_data (evt_dout),
    .empty   (evt_empty),
    .level   (evt_level)
  );

  assign bus.in_ready                     = ready;
  assign bus.mdt_hit_top                  = hit_dout;
  assign bus.mdt_hit_top_empty            = hit_empty;
  assign bus.hit_extraction_roi_top       = evt_dout[ROI_W-1:0];
  assign bus.hit_extraction_roi_empty     = evt_empty;
  assign bus.histogram_accumulation_count = 10'(evt_dout[EW-1:ROI_W]);

`ifdef LSF_FEEDER_STATS_EN
  logic        drop_hit;
  logic [15:0] dropped_q;
  logic [15:0] events_q;

  // Any valid hit not written to the FIFO (cap reached, or outside COLLECT) counts as dropped.
  assign drop_hit = bus.hit_in_vld && !hit_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_q <= '0;
      events_q  <= '0;
    end else begin
      if (drop_hit && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
      if (evt_push) events_q <= events_q + 16'd1;
    end
  end

  assign bus.dropped_hits = dropped_q;
  assign bus.events_out   = events_q;
`else
  assign bus.dropped_hits = '0;
  assign bus.events_out   = '0;
`endif

endmodule

// File: tb/tb_lsf_hit_feeder.sv
// Scoreboard bench for lsf_hit_feeder: expected hits/events queued at drive time, checked on pop.
// Statistics expectations follow LSF_FEEDER_STATS_EN the same way as the design build.
module tb_lsf_hit_feeder;
  import lsf_feeder_pkg::*;

  localparam int HIT_W = HPS_LSF_LEN;
  localparam int ROI_W = SLCPROC_HPS_SF_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lsf_hit_feeder_if #(.HIT_W(HIT_W), .ROI_W(ROI_W)) bus ();

  lsf_hit_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [HIT_W-1:0] hit_q [$];
  evt_entry_t       evt_q [$];
  int               total = 0;
  int               bad   = 0;
  int               cur_cnt;
  logic [ROI_W-1:0] cur_roi;
  logic [15:0]      exp_dropped = '0;
  logic [15:0]      exp_events  = '0;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] stat_exp(input logic [15:0] v);
`ifdef LSF_FEEDER_STATS_EN
    return v;
`else
    return (v & 16'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic close_expected();
    evt_entry_t e;
    e.count = COUNT_W'(cur_cnt);
    e.roi   = cur_roi;
    evt_q.push_back(e);
    exp_events = exp_events + 16'd1;
  endtask

  task automatic send_roi(input logic [ROI_W-1:0] r);
    int waited = 0;
    while (!bus.in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) check_output("roi_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.roi_in     = r;
    bus.roi_in_vld = 1'b1;
    tick();
    bus.roi_in_vld = 1'b0;
    cur_roi = r;
    cur_cnt = 0;
  endtask

  task automatic send_hit(input logic [HIT_W-1:0] h, input logic last);
    bus.hit_in      = h;
    bus.hit_in_vld  = 1'b1;
    bus.hit_in_last = last;
    if (cur_cnt < MAX_HITS_DEFAULT) begin
      hit_q.push_back(h);
      cur_cnt++;
    end else begin
      exp_dropped = exp_dropped + 16'd1;
    end
    tick();
    bus.hit_in_vld  = 1'b0;
    bus.hit_in_last = 1'b0;
    if (last) close_expected();
  endtask

  task automatic send_event(input logic [ROI_W-1:0] r, input int n, input int tag);
    send_roi(r);
    for (int i = 1; i <= n; i++)
      send_hit(HIT_W'(64'hA0_0000_0000 + (64'(tag) << 16) + 64'(i)), (i == n));
  endtask

  task automatic pop_event(input int skip);
    evt_entry_t       e;
    logic [HIT_W-1:0] exp_hit;
    int               waited = 0;
    while (bus.hit_extraction_roi_empty && waited < 100) begin
      tick();
      waited++;
    end
    check_output("evt_avail", 64'(bus.hit_extraction_roi_empty), 64'd0);
    if (evt_q.size() == 0) begin
      check_output("evt_sb_underflow", 64'(evt_q.size()), 64'd1);
      return;
    end
    e = evt_q.pop_front();
    check_output("evt_roi", 64'(bus.hit_extraction_roi_top), 64'(e.roi));
    check_output("evt_count", 64'(bus.histogram_accumulation_count), 64'(e.count));
    bus.hit_extraction_roi_re = 1'b1;
    tick();
    bus.hit_extraction_roi_re = 1'b0;
    for (int i = 0; i < int'(e.count) - skip; i++) begin
      check_output("hit_avail", 64'(bus.mdt_hit_top_empty), 64'd0);
      exp_hit = hit_q.pop_front();
      check_output("hit_data", 64'(bus.mdt_hit_top), 64'(exp_hit));
      bus.mdt_hit_top_re = 1'b1;
      tick();
      bus.mdt_hit_top_re = 1'b0;
    end
    check_output("hit_empty_after_pop", 64'(bus.mdt_hit_top_empty), 64'(hit_q.size() == 0));
  endtask

  task automatic check_stats(input string tag);
    check_output({tag, "_dropped"}, 64'(bus.dropped_hits), 64'(stat_exp(exp_dropped)));
    check_output({tag, "_events"}, 64'(bus.events_out), 64'(stat_exp(exp_events)));
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check_output({tag, "_hit_empty"}, 64'(bus.mdt_hit_top_empty), 64'd1);
    check_output({tag, "_evt_empty"}, 64'(bus.hit_extraction_roi_empty), 64'd1);
    check_output({tag, "_hit_top"}, 64'(bus.mdt_hit_top), 64'd0);
    check_output({tag, "_roi_top"}, 64'(bus.hit_extraction_roi_top), 64'd0);
    check_output({tag, "_count"}, 64'(bus.histogram_accumulation_count), 64'd0);
    check_stats(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [HIT_W-1:0] h;
    bus.roi_in = '0;
    bus.roi_in_vld = 1'b0;
    bus.hit_in = '0;
    bus.hit_in_vld = 1'b0;
    bus.hit_in_last = 1'b0;
    bus.eoe_in = 1'b0;
    bus.mdt_hit_top_re = 1'b0;
    bus.hit_extraction_roi_re = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check_output("ready_after_reset", 64'(bus.in_ready), 64'd1);

    $display("[TB] basic event: 5 hits");
    send_event(ROI_W'(39'h11_2233_4455), 5, 1);
    check_output("evt_empty_in_close", 64'(bus.hit_extraction_roi_empty), 64'd1);
    tick();
    check_output("evt_visible_after_close", 64'(bus.hit_extraction_roi_empty), 64'd0);
    pop_event(0);
    check_stats("ev1");

    $display("[TB] overflow event: 40 hits");
    send_event(ROI_W'(39'h22_0000_0002), 40, 2);
    pop_event(0);
    check_stats("ev2");

    $display("[TB] stray hit in IDLE, then zero-hit event");
    bus.hit_in = HIT_W'(64'hDEAD);
    bus.hit_in_vld = 1'b1;
    exp_dropped = exp_dropped + 16'd1;
    tick();
    bus.hit_in_vld = 1'b0;
    send_roi(ROI_W'(39'h33_0000_0003));
    bus.eoe_in = 1'b1;
    tick();
    bus.eoe_in = 1'b0;
    close_expected();
    tick();
    check_output("zero_hit_fifo_empty", 64'(bus.mdt_hit_top_empty), 64'd1);
    pop_event(0);
    check_stats("ev3");

    $display("[TB] backpressure: 4 events of 10 hits, no reads");
    for (int k = 0; k < 4; k++) send_event(ROI_W'(39'h40_0000_0000 + 39'(k)), 10, 10 + k);
    tick();
    tick();
    check_output("ready_low_when_full", 64'(bus.in_ready), 64'd0);
    pop_event(0);
    check_output("ready_after_one_pop", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 3; k++) pop_event(0);
    check_stats("ev4");

    $display("[TB] reset in the middle of an event");
    send_roi(ROI_W'(39'h55_0000_0005));
    for (int i = 1; i <= 3; i++) send_hit(HIT_W'(64'hB00 + 64'(i)), 1'b0);
    rst = 1'b1;
    tick();
    check_reset_state("midreset");
    rst = 1'b0;
    hit_q.delete();
    evt_q.delete();
    exp_dropped = '0;
    exp_events = '0;
    tick();
    check_output("ready_after_midreset", 64'(bus.in_ready), 64'd1);
    send_event(ROI_W'(39'h66_0000_0006), 6, 6);
    pop_event(0);
    check_stats("ev5");

    $display("[TB] simultaneous push and pop on a 1-entry hit FIFO");
    send_roi(ROI_W'(39'h77_0000_0007));
    send_hit(HIT_W'(64'hC01), 1'b0);
    check_output("one_entry_not_empty", 64'(bus.mdt_hit_top_empty), 64'd0);
    h = hit_q.pop_front();
    check_output("one_entry_head", 64'(bus.mdt_hit_top), 64'(h));
    bus.mdt_hit_top_re = 1'b1;
    send_hit(HIT_W'(64'hC02), 1'b0);
    bus.mdt_hit_top_re = 1'b0;
    check_output("pushpop_not_empty", 64'(bus.mdt_hit_top_empty), 64'd0);
    check_output("pushpop_head", 64'(bus.mdt_hit_top), 64'(hit_q[0]));
    send_hit(HIT_W'(64'hC03), 1'b1);
    pop_event(1);
    check_stats("ev6");

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
